// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote,
// parity/framing/break/overrun detection and a small valid/ready output FIFO.
module uart_rx_param #(
    parameter int clksPerBit = 234,
    parameter int dataBits   = 8,
    parameter int parityMode = 1,
    parameter int stopBits   = 1,
    parameter int fifoDepth  = 4
) (
    input  logic                i_clkRx,
    input  logic                i_rstRx_n,
    input  logic                i_rxSerial,
    input  logic                i_rdReady,
    output logic                o_rxValid,
    output logic [dataBits-1:0] o_rxData,
    output logic                o_parityError,
    output logic                o_frameError,
    output logic                o_breakDetect,
    output logic                o_overrun,
    output logic                o_busy
);
    localparam int cntW  = $clog2(clksPerBit + 1);
    localparam int idxW  = $clog2(dataBits);
    localparam int addrW = $clog2(fifoDepth);
    localparam int entW  = dataBits + 2;

    localparam logic [cntW-1:0] sampA   = cntW'(clksPerBit / 2 - 1);
    localparam logic [cntW-1:0] sampB   = cntW'(clksPerBit / 2);
    localparam logic [cntW-1:0] sampC   = cntW'(clksPerBit / 2 + 1);
    localparam logic [cntW-1:0] cntLast = cntW'(clksPerBit - 1);
    localparam logic [idxW-1:0] dataLast = idxW'(dataBits - 1);
    localparam logic [idxW-1:0] stopLast = idxW'(stopBits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} rxState_t;

    rxState_t state, stateNext;

    logic syncA, syncB, rxLine;
    logic [cntW-1:0] bitCnt;
    logic [idxW-1:0] bitIdx;
    logic sampleA, sampleB;
    logic [dataBits-1:0] shiftReg;
    logic parityBit, frameErr, stopAllZero;
    logic bitTick, bitVal, frameErrNow, parityErrNow, isBreak;
    logic pushReq, breakHit;

    logic [entW-1:0] fifoMem [fifoDepth];
    logic [addrW:0] wrPtr, rdPtr;
    logic [entW-1:0] headEntry;
    logic fifoEmpty, fifoFull, popEn, pushEn;

    // Sync flops preset to 1 so reset release never looks like a start bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clkRx or negedge i_rstRx_n) begin
        if (!i_rstRx_n) begin
            syncA <= 1'b1;
            syncB <= 1'b1;
        end else begin
            syncA <= i_rxSerial;
            syncB <= syncA;
        end
    end
    assign rxLine = syncB;

    assign bitVal  = (sampleA & sampleB) | (sampleA & rxLine) | (sampleB & rxLine);
    assign bitTick = (bitCnt == sampC) && (state inside {START, DATA, PARITY, STOP});

    always_comb begin
        parityErrNow = 1'b0;
        if (parityMode == 1)      parityErrNow = (^shiftReg) != parityBit;
        else if (parityMode == 2) parityErrNow = (~^shiftReg) != parityBit;
    end

    assign frameErrNow = frameErr | ~bitVal;
    assign isBreak = (shiftReg == '0) && ((parityMode == 0) || !parityBit) && stopAllZero && !bitVal;

    always_ff @(posedge i_clkRx or negedge i_rstRx_n) begin
        if (!i_rstRx_n) state <= IDLE;
        else            state <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        stateNext = state;
        pushReq   = 1'b0;
        breakHit  = 1'b0;
        case (state)
            IDLE:    if (!rxLine) stateNext = START;
            START:   if (bitTick) stateNext = bitVal ? IDLE : DATA;
            DATA:    if (bitTick && bitIdx == dataLast)
                         stateNext = (parityMode != 0) ? PARITY : STOP;
            PARITY:  if (bitTick) stateNext = STOP;
            STOP: begin
                if (bitTick && bitIdx == stopLast) begin
                    if (isBreak) begin
                        breakHit  = 1'b1;
                        stateNext = BRKWAIT;
                    end else begin
                        pushReq   = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            BRKWAIT: if (rxLine && bitCnt == cntLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The bit counter runs freely through a frame; each bit is decided on the third sample.
    always_ff @(posedge i_clkRx or negedge i_rstRx_n) begin
        if (!i_rstRx_n) begin
            bitCnt      <= '0;
            bitIdx      <= '0;
            sampleA     <= 1'b1;
            sampleB     <= 1'b1;
            shiftReg    <= '0;
            parityBit   <= 1'b0;
            frameErr    <= 1'b0;
            stopAllZero <= 1'b0;
        end else begin
            case (state)
                IDLE:    bitCnt <= '0;
                BRKWAIT: bitCnt <= rxLine ? bitCnt + 1'b1 : '0;
                default: bitCnt <= (bitCnt == cntLast) ? '0 : bitCnt + 1'b1;
            endcase
            if (breakHit) bitCnt <= '0;
            if (bitCnt == sampA) sampleA <= rxLine;
            if (bitCnt == sampB) sampleB <= rxLine;
            if (bitTick) begin
                case (state)
                    START: begin
                        bitIdx      <= '0;
                        frameErr    <= 1'b0;
                        stopAllZero <= 1'b1;
                    end
                    DATA: begin
                        shiftReg <= {bitVal, shiftReg[dataBits-1:1]};
                        bitIdx   <= (bitIdx == dataLast) ? '0 : bitIdx + 1'b1;
                    end
                    PARITY: parityBit <= bitVal;
                    STOP: begin
                        bitIdx      <= bitIdx + 1'b1;
                        frameErr    <= frameErrNow;
                        stopAllZero <= stopAllZero & ~bitVal;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pop is resolved first, so a full FIFO still accepts a push in a popping cycle.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[addrW] != rdPtr[addrW]) && (wrPtr[addrW-1:0] == rdPtr[addrW-1:0]);
    assign popEn     = ~fifoEmpty & i_rdReady;
    assign pushEn    = pushReq & (~fifoFull | popEn);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clkRx) begin
        if (pushEn) fifoMem[wrPtr[addrW-1:0]] <= {shiftReg, parityErrNow, frameErrNow};
    end

    always_ff @(posedge i_clkRx or negedge i_rstRx_n) begin
        if (!i_rstRx_n) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            o_breakDetect <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + 1'b1;
            if (popEn)  rdPtr <= rdPtr + 1'b1;
            o_breakDetect <= breakHit;
            o_overrun     <= pushReq & fifoFull & ~popEn;
        end
    end

    assign headEntry     = fifoMem[rdPtr[addrW-1:0]];
    assign o_rxValid     = ~fifoEmpty;
    assign o_rxData      = fifoEmpty ? '0 : headEntry[entW-1:2];
    assign o_parityError = ~fifoEmpty & headEntry[1];
    assign o_frameError  = ~fifoEmpty & headEntry[0];
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: even- and odd-parity instances share one line and are
// checked every cycle against frame-level expectation queues.
module tb_uart_rx_param;
    localparam int cpb = 16;

    logic clk = 1'b0;
    logic rst_n, rx, rdy;
    logic vE, peE, feE, brkE, ovrE, busyE;
    logic vO, peO, feO, brkO, ovrO, busyO;
    logic [7:0] dE, dO;

    uart_rx_param #(.clksPerBit(cpb), .dataBits(8), .parityMode(1), .stopBits(1), .fifoDepth(4)) dutE (
        .i_clkRx(clk), .i_rstRx_n(rst_n), .i_rxSerial(rx), .i_rdReady(rdy),
        .o_rxValid(vE), .o_rxData(dE), .o_parityError(peE), .o_frameError(feE),
        .o_breakDetect(brkE), .o_overrun(ovrE), .o_busy(busyE));

    uart_rx_param #(.clksPerBit(cpb), .dataBits(8), .parityMode(2), .stopBits(1), .fifoDepth(4)) dutO (
        .i_clkRx(clk), .i_rstRx_n(rst_n), .i_rxSerial(rx), .i_rdReady(rdy),
        .o_rxValid(vO), .o_rxData(dO), .o_parityError(peO), .o_frameError(feO),
        .o_breakDetect(brkO), .o_overrun(ovrO), .o_busy(busyO));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nVec = 0, nErr = 0;
    logic [9:0] qE[$], qO[$], logE[$], logO[$];
    int expOvr = 0, expBrk = 0, cntOvrE = 0, cntOvrO = 0, cntBrkE = 0, cntBrkO = 0;
    int lastStart = 0, lastRise = 0, pulseAt = 0;
    bit randReady = 0;
    logic prevVE = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Expected entries are queued when a frame starts; the DUT head must match while valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outE", {vE, dE, peE, feE, brkE, ovrE, busyE}, 0);
            check("rst_outO", {vO, dO, peO, feO, brkO, ovrO, busyO}, 0);
        end else begin
            if (vE && !prevVE) lastRise = cyc;
            if (vE) begin
                if (qE.size() == 0) begin
                    nVec++; nErr++;
                    $display("FAIL unexpected_pushE: got %h, required no entry", {dE, peE, feE});
                end else begin
                    check("headE", {dE, peE, feE}, qE[0]);
                    if (rdy) begin logE.push_back({dE, peE, feE}); void'(qE.pop_front()); end
                end
            end
            if (vO) begin
                if (qO.size() == 0) begin
                    nVec++; nErr++;
                    $display("FAIL unexpected_pushO: got %h, required no entry", {dO, peO, feO});
                end else begin
                    check("headO", {dO, peO, feO}, qO[0]);
                    if (rdy) begin logO.push_back({dO, peO, feO}); void'(qO.pop_front()); end
                end
            end
            if (ovrE) cntOvrE++;
            if (ovrO) cntOvrO++;
            if (brkE) cntBrkE++;
            if (brkO) cntBrkO++;
        end
        prevVE = vE;
    end

    task automatic step(input logic v);
        rx = v;
        if (randReady)        rdy = 1'($urandom_range(0, 1));
        else if (pulseAt > 0) rdy = (cyc == pulseAt - 1);
        @(posedge clk); #1;
    endtask

    task automatic driveBit(input logic v, input int gOff);
        for (int c = 0; c < cpb; c++) step((c == gOff) ? ~v : v);
    endtask

    task automatic idleBits(input int n);
        for (int c = 0; c < cpb * n; c++) step(1'b1);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic pbit, input logic stopV,
                             input bit acceptPop, input int gBit, input int gOff);
        if (d == 8'h00 && !pbit && !stopV) expBrk++;
        else if (qE.size() >= 4 && !acceptPop && !rdy && !randReady) expOvr++;
        else begin
            qE.push_back({d, logic'((^d) != pbit), ~stopV});
            qO.push_back({d, logic'((~^d) != pbit), ~stopV});
        end
        lastStart = cyc;
        driveBit(1'b0, -1);
        for (int i = 0; i < 8; i++) driveBit(d[i], (i == gBit) ? gOff : -1);
        driveBit(pbit, -1);
        driveBit(stopV, -1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((qE.size() != 0 || qO.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", qE.size() + qO.size(), 0);
    endtask

    initial begin
        int lat, s, logN;
        logic [7:0] d;
        logic pb, sv;
        int gb;

        rst_n = 1'b1; rx = 1'b1; rdy = 1'b0;
        #2 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        idleBits(2);
        check("idle_busy", busyE, 0);

        // Basic frame, latency window and exact contents
        rdy = 1'b1;
        sendFrame(8'hA5, 1'b0, 1'b1, 0, -1, 0);
        waitDrain(200);
        lat = lastRise - lastStart;
        check("latency_window", (lat >= 168 && lat <= 176), 1);
        check("a5_even", logE[$], {8'hA5, 2'b00});
        check("a5_odd_perr", logO[$], {8'hA5, 2'b10});
        idleBits(1);

        // Bad even parity, good odd parity
        sendFrame(8'h01, 1'b0, 1'b1, 0, -1, 0);
        waitDrain(200);
        check("01_even_perr", logE[$], {8'h01, 2'b10});
        check("01_odd_ok", logO[$], {8'h01, 2'b00});

        // Framing error, then clean frame
        sendFrame(8'h3C, 1'b0, 1'b0, 0, -1, 0);
        idleBits(2);
        sendFrame(8'h55, 1'b0, 1'b1, 0, -1, 0);
        waitDrain(200);
        check("3c_ferr", logE[$-1], {8'h3C, 2'b01});
        check("55_clean", logE[$], {8'h55, 2'b00});
        idleBits(1);

        // Idle glitch rejected; in-bit glitch majority-filtered
        logN = logE.size();
        for (int c = 0; c < 3; c++) step(1'b0);
        idleBits(2);
        check("glitch_nopush", logE.size(), logN);
        check("glitch_idle_busy", busyE, 0);
        sendFrame(8'hFF, 1'b0, 1'b1, 0, 3, 9);
        waitDrain(200);
        check("ff_filtered", logE[$], {8'hFF, 2'b00});
        idleBits(1);

        // Overrun on the fifth back-to-back frame
        rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k * 8'h11);
            sendFrame(d, ^d, 1'b1, 0, -1, 0);
        end
        idleBits(1);
        check("overrun_once", cntOvrE, 1);
        check("overrun_onceO", cntOvrO, 1);
        rdy = 1'b1;
        waitDrain(50);
        check("pop0", logE[$-3], {8'h11, 2'b00});
        check("pop1", logE[$-2], {8'h22, 2'b00});
        check("pop2", logE[$-1], {8'h33, 2'b00});
        check("pop3", logE[$], {8'h44, 2'b00});

        // Full FIFO with push and pop in the same cycle
        rdy = 1'b0;
        sendFrame(8'h81, 1'b0, 1'b1, 0, -1, 0);
        sendFrame(8'h42, 1'b0, 1'b1, 0, -1, 0);
        sendFrame(8'h24, 1'b0, 1'b1, 0, -1, 0);
        sendFrame(8'h18, 1'b0, 1'b1, 0, -1, 0);
        s = cyc;
        pulseAt = s + lat;
        sendFrame(8'h99, 1'b0, 1'b1, 1, -1, 0);
        pulseAt = 0;
        rdy = 1'b0;
        idleBits(1);
        check("simul_no_overrun", cntOvrE, expOvr);
        rdy = 1'b1;
        waitDrain(50);
        check("simul_q0", logE[$-3], {8'h42, 2'b00});
        check("simul_q3", logE[$], {8'h99, 2'b00});

        // Break: line low for 12 bit times
        expBrk++;
        for (int c = 0; c < cpb * 12; c++) step(1'b0);
        idleBits(2);
        check("break_once", cntBrkE, 1);
        check("break_onceO", cntBrkO, 1);
        sendFrame(8'h3C, 1'b0, 1'b1, 0, -1, 0);
        waitDrain(200);
        check("post_break_3c", logE[$], {8'h3C, 2'b00});
        idleBits(1);

        // Randomised frames with random consumer readiness
        randReady = 1;
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 3) != 0);
            if (d == 8'h00 && !pb && !sv) d = 8'h01;
            gb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            sendFrame(d, pb, sv, 0, gb, $urandom_range(0, 15));
            if (!sv) idleBits(2);
            else if ($urandom_range(0, 1) == 1) idleBits(1);
        end
        randReady = 0;
        rdy = 1'b1;
        waitDrain(400);
        idleBits(1);

        // Reset mid-frame with entries pending
        rdy = 1'b0;
        sendFrame(8'h5A, 1'b0, 1'b1, 0, -1, 0);
        sendFrame(8'hC3, 1'b0, 1'b1, 0, -1, 0);
        driveBit(1'b0, -1);
        driveBit(1'b1, -1);
        driveBit(1'b0, -1);
        for (int c = 0; c < 5; c++) step(1'b1);
        rst_n = 1'b0;
        qE.delete();
        qO.delete();
        idleBits(1);
        rst_n = 1'b1;
        idleBits(2);
        check("post_reset_valid", vE, 0);
        check("post_reset_busy", busyE, 0);

        check("overrun_total", cntOvrE, expOvr);
        check("break_total", cntBrkE, expBrk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
